// File: rtl/bus_master_port.sv
// bus_master_port: bus requester that waits for its grant, runs the address/data handshake and reports completion; BMP_TIMEOUT_EN adds an abort timer
module bus_master_port #(
  parameter logic [1:0] MASTER_ID = 2'b11,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              breq,
  input  logic [1:0]        bgrant,
  output logic              m_valid,
  output logic              m_mode,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              s_ready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_RDATA, S_DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, m_wdata_q, m_wdata_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic done_q, done_d, err_q, err_d, busy_q, busy_d, breq_q, breq_d;
  logic m_valid_q, m_valid_d, m_mode_q, m_mode_d;
  logic granted;
  assign granted = bgrant == MASTER_ID;
`ifdef BMP_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic active;
  assign active = state_q inside {S_REQ, S_ADDR, S_RDATA};
  // Abort timer: cleared when a command is accepted, runs while the transfer is in flight
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif
  // Next-state and next-output logic; DONE markers are derived from the next state so all paths into DONE agree
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    done_d = 1'b0;
    err_d = 1'b0;
    busy_d = busy_q;
    breq_d = breq_q;
    m_valid_d = m_valid_q;
    m_mode_d = m_mode_q;
    m_addr_d = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        m_mode_d = mode;
        m_addr_d = addr;
        m_wdata_d = wdata;
        busy_d = 1'b1;
        breq_d = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: if (granted) begin
        m_valid_d = 1'b1;
        state_d = S_ADDR;
      end
      S_ADDR: if (s_ready) begin
        m_valid_d = 1'b0;
        state_d = m_mode_q ? S_DONE : S_RDATA;
      end else if (!granted) begin
        m_valid_d = 1'b0;
        state_d = S_REQ;
      end
      S_RDATA: if (s_rvalid) begin
        rdata_d = s_rdata;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BMP_TIMEOUT_EN
    cnt_d = (state_q == S_IDLE && start) ? '0 : cnt_q;
    if (active && cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
      state_d = S_DONE;
      err_d = 1'b1;
      m_valid_d = 1'b0;
      rdata_d = rdata_q;
    end else if (active) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      breq_d = 1'b0;
    end
  end
  // State and registered outputs, all cleared asynchronously
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      breq_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_mode_q <= 1'b0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      done_q <= done_d;
      err_q <= err_d;
      busy_q <= busy_d;
      breq_q <= breq_d;
      m_valid_q <= m_valid_d;
      m_mode_q <= m_mode_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  assign rdata = rdata_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = busy_q;
  assign breq = breq_q;
  assign m_valid = m_valid_q;
  assign m_mode = m_mode_q;
  assign m_addr = m_addr_q;
  assign m_wdata = m_wdata_q;
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed and randomized checks of bus_master_port against a transaction-level expectation
module tb_bus_master_port;
  logic clk = 1'b0, rstn = 1'b0;
  logic start = 1'b0, start1 = 1'b0, start_to = 1'b0, mode = 1'b0;
  logic [11:0] addr = '0;
  logic [7:0] wdata = '0, s_rdata = '0;
  logic [1:0] bgrant = 2'b00;
  logic s_ready = 1'b0, s_rvalid = 1'b0;
  logic [7:0] rdata, rdata_1, rdata_t, m_wdata, m_wdata_1, m_wdata_t;
  logic [11:0] m_addr, m_addr_1, m_addr_t;
  logic done, err, busy, breq, m_valid, m_mode;
  logic done_1, err_1, busy_1, breq_1, m_valid_1, m_mode_1;
  logic done_t, err_t, busy_t, breq_t, m_valid_t, m_mode_t;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  bus_master_port #(.MASTER_ID(2'b10)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .busy(busy), .breq(breq), .bgrant(bgrant),
    .m_valid(m_valid), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));
  bus_master_port #(.MASTER_ID(2'b11)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .mode(mode), .addr(addr), .wdata(wdata),
    .rdata(rdata_1), .done(done_1), .err(err_1), .busy(busy_1), .breq(breq_1), .bgrant(bgrant),
    .m_valid(m_valid_1), .m_mode(m_mode_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));
  bus_master_port #(.MASTER_ID(2'b10), .TIMEOUT_CYCLES(10)) dut_to (
    .clk(clk), .rstn(rstn), .start(start_to), .mode(mode), .addr(addr), .wdata(wdata),
    .rdata(rdata_t), .done(done_t), .err(err_t), .busy(busy_t), .breq(breq_t), .bgrant(bgrant),
    .m_valid(m_valid_t), .m_mode(m_mode_t), .m_addr(m_addr_t), .m_wdata(m_wdata_t),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic other_grant(output logic [1:0] g);
    logic [1:0] opts [3];
    opts = '{2'b00, 2'b01, 2'b11};
    g = opts[$urandom_range(0, 2)];
  endtask

  initial begin
    logic [7:0] exp_rdata, rd;
    logic [11:0] ca;
    logic [7:0] cw;
    logic cm;
    int n;
    tick();
    chk("rst_rdata", rdata, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_busy", busy, 0); chk("rst_breq", breq, 0); chk("rst_mvalid", m_valid, 0);
    chk("rst_mmode", m_mode, 0); chk("rst_maddr", m_addr, 0); chk("rst_mwdata", m_wdata, 0);
    rstn = 1'b1;
    exp_rdata = 8'h00;
    tick();
    // earliest write on the ID 2'b11 instance
    start1 = 1'b1; mode = 1'b1; addr = 12'h0A5; wdata = 8'h3C;
    tick();
    start1 = 1'b0; addr = 12'hFFF; wdata = 8'hFF;
    chk("wr_breq", breq_1, 1); chk("wr_busy", busy_1, 1); chk("wr_mvalid_early", m_valid_1, 0);
    bgrant = 2'b11;
    tick();
    chk("wr_mvalid", m_valid_1, 1); chk("wr_maddr", m_addr_1, 12'h0A5);
    chk("wr_mwdata", m_wdata_1, 8'h3C); chk("wr_mmode", m_mode_1, 1);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; bgrant = 2'b00;
    chk("wr_done", done_1, 1); chk("wr_err", err_1, 0); chk("wr_breq_off", breq_1, 0);
    chk("wr_busy_off", busy_1, 0); chk("wr_mvalid_off", m_valid_1, 0);
    tick();
    chk("wr_done_pulse", done_1, 0);
    // read on ID 2'b10 with the other master granted first
    start = 1'b1; mode = 1'b0; addr = 12'h3E1; wdata = 8'h77;
    tick();
    start = 1'b0; bgrant = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_no_mvalid", m_valid, 0);
    end
    bgrant = 2'b10;
    tick();
    chk("rd_mvalid", m_valid, 1); chk("rd_maddr", m_addr, 12'h3E1); chk("rd_mmode", m_mode, 0);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("rd_mvalid_off", m_valid, 0); chk("rd_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_wait_done", done, 0);
    end
    s_rvalid = 1'b1; s_rdata = 8'h5A;
    tick();
    s_rvalid = 1'b0; exp_rdata = 8'h5A;
    chk("rd_done", done, 1); chk("rd_rdata", rdata, exp_rdata); chk("rd_err", err, 0);
    tick();
    // pre-emption in ADDR, then ready together with grant loss
    start = 1'b1; mode = 1'b1; addr = 12'h2C3; wdata = 8'h99;
    tick();
    start = 1'b0; bgrant = 2'b10;
    tick();
    chk("pe_mvalid", m_valid, 1);
    bgrant = 2'b11;
    tick();
    chk("pe_drop", m_valid, 0); chk("pe_breq", breq, 1);
    tick();
    chk("pe_wait", m_valid, 0);
    bgrant = 2'b10;
    tick();
    chk("pe_regrant", m_valid, 1); chk("pe_maddr", m_addr, 12'h2C3); chk("pe_mwdata", m_wdata, 8'h99);
    s_ready = 1'b1; bgrant = 2'b11;
    tick();
    s_ready = 1'b0;
    chk("pe_done", done, 1); chk("pe_rdata_kept", rdata, exp_rdata);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(done);
    end
    chk("pe_single_done", n, 0);
    // asynchronous reset during the data phase
    bgrant = 2'b00;
    start = 1'b1; mode = 1'b0; addr = 12'h123;
    tick();
    start = 1'b0; bgrant = 2'b10;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("ar_rdata", rdata, 0); chk("ar_busy", busy, 0); chk("ar_breq", breq, 0);
    chk("ar_maddr", m_addr, 0); chk("ar_mvalid", m_valid, 0); chk("ar_done", done, 0);
    tick();
    rstn = 1'b1; exp_rdata = 8'h00;
    s_rvalid = 1'b1; s_rdata = 8'hE7;
    tick();
    s_rvalid = 1'b0;
    chk("ar_stray_rvalid", rdata, exp_rdata); chk("ar_idle", busy, 0);
    start = 1'b1; mode = 1'b0; addr = 12'h456;
    tick();
    start = 1'b0;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; s_rvalid = 1'b1; s_rdata = 8'hC4;
    tick();
    s_rvalid = 1'b0; exp_rdata = 8'hC4;
    chk("ar_new_done", done, 1); chk("ar_new_rdata", rdata, exp_rdata);
    tick();
    // start while busy and on the DONE cycle
    start = 1'b1; mode = 1'b1; addr = 12'h111; wdata = 8'h22; bgrant = 2'b00;
    tick();
    addr = 12'h333; wdata = 8'h44;
    tick();
    start = 1'b0; bgrant = 2'b10;
    tick();
    chk("bz_maddr", m_addr, 12'h111); chk("bz_mwdata", m_wdata, 8'h22);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("bz_done", done, 1);
    start = 1'b1; addr = 12'h555;
    tick();
    start = 1'b0;
    chk("bz_done_start", busy, 0); chk("bz_done_breq", breq, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(done);
    end
    chk("bz_one_done", n, 0); chk("bz_maddr_kept", m_addr, 12'h111);
    // randomized transactions on the ID 2'b10 instance
    for (int t = 0; t < 30; t++) begin
      cm = 1'($urandom_range(0, 1)); ca = 12'($urandom); cw = 8'($urandom);
      start = 1'b1; mode = cm; addr = ca; wdata = cw;
      tick();
      start = 1'($urandom_range(0, 1)); mode = ~cm; addr = ~ca; wdata = ~cw;
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        other_grant(bgrant);
        s_rvalid = 1'($urandom_range(0, 1)); s_rdata = 8'($urandom);
        tick();
        start = 1'b0;
        chk("rn_wait", m_valid, 0);
      end
      start = 1'b0; s_rvalid = 1'b0; bgrant = 2'b10;
      tick();
      chk("rn_mvalid", m_valid, 1); chk("rn_maddr", m_addr, ca);
      chk("rn_mwdata", m_wdata, cw); chk("rn_mmode", m_mode, cm);
      if ($urandom_range(0, 1) == 1) begin
        other_grant(bgrant);
        tick();
        chk("rn_pe", m_valid, 0);
        bgrant = 2'b10;
        tick();
        chk("rn_pe_addr", m_addr, ca);
      end
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0;
      other_grant(bgrant);
      if (!cm) begin
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
          tick();
          chk("rn_rd_wait", done, 0);
        end
        rd = 8'($urandom);
        s_rvalid = 1'b1; s_rdata = rd;
        tick();
        s_rvalid = 1'b0; exp_rdata = rd;
      end
      chk("rn_done", done, 1); chk("rn_err", err, 0); chk("rn_rdata", rdata, exp_rdata);
      tick();
      chk("rn_idle", {done, busy, breq, m_valid}, 0);
    end
    bgrant = 2'b00;
`ifdef BMP_TIMEOUT_EN
    start_to = 1'b1; mode = 1'b0;
    tick();
    start_to = 1'b0;
    n = 0;
    for (int i = 0; i <= 10; i++) begin
      n += int'(done_t) + int'(!breq_t);
      tick();
    end
    chk("to_early", n, 0);
    chk("to_done", done_t, 1); chk("to_err", err_t, 1);
    chk("to_breq", breq_t, 0); chk("to_mvalid", m_valid_t, 0); chk("to_rdata", rdata_t, 0);
    tick();
    chk("to_pulse", {done_t, err_t, busy_t}, 0);
`else
    start_to = 1'b1; mode = 1'b0;
    tick();
    start_to = 1'b0;
    n = 0;
    for (int i = 0; i < 120; i++) begin
      n += int'(breq_t && !done_t && !err_t);
      tick();
    end
    chk("nto_breq_held", n, 120);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
